// File: rtl/sdf_stage_ctrl.sv
// rtl/sdf_stage_ctrl.sv - index/phase sequencer for one radix-2 SDF FFT pipeline stage
// Define SDF_CTRL_STATS_EN to add saturating frame_cnt/err_cnt outputs.
module sdf_stage_ctrl #(
  parameter int N_LOG2 = 4,
  parameter int STAGE  = 0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              in_valid,
  input  logic              in_sof,
  output logic              bf_sel,
  output logic              tw_en,
  output logic [N_LOG2-2:0] tw_addr,
  output logic              out_valid,
  output logic              out_sof,
  output logic              dl_clear,
  output logic              err,
  output logic              busy
`ifdef SDF_CTRL_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [7:0]        err_cnt
`endif
);

  localparam int D = 1 << (N_LOG2 - STAGE - 1);
  localparam logic [N_LOG2-1:0] D_V  = N_LOG2'(D);
  localparam logic [N_LOG2-1:0] D_M1 = N_LOG2'(D - 1);
  localparam logic [N_LOG2-1:0] LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t            state_q, state_d;
  logic [N_LOG2-1:0] cnt_q, cnt_d;
  logic [N_LOG2-1:0] fcnt_q, fcnt_d;
  logic              inflight_q, inflight_d;
  logic              err_q, err_d;
  logic              dl_clear_q, dl_clear_d;
  logic              frame_inc;

  logic              run, flush, phase_hi, ge_d, ge_2d, wrap_pend;
  logic [N_LOG2-1:0] addr_full;

  // After a wrap the stage sits at cnt=0 with the previous frame's tail still
  // in the delay line; this cycle is either sample 0 of the next frame or the
  // first flush cycle, and both decode identically.
  assign run       = (state_q == S_RUN);
  assign flush     = (state_q == S_FLUSH);
  assign phase_hi  = (cnt_q & D_V) != '0;
  assign ge_d      = cnt_q >= D_V;
  assign ge_2d     = {1'b0, cnt_q} >= (N_LOG2+1)'(2 * D);
  assign wrap_pend = run && inflight_q && (cnt_q == '0);

  always_comb begin
    bf_sel    = run && phase_hi;
    tw_en     = (run && !phase_hi && (ge_2d || inflight_q)) || flush;
    addr_full = run ? ((cnt_q & D_M1) << STAGE) : (fcnt_q << STAGE);
    tw_addr   = tw_en ? addr_full[N_LOG2-2:0] : '0;
    out_valid = (run && ((in_valid && (ge_d || inflight_q)) || wrap_pend)) || flush;
    out_sof   = run && in_valid && (cnt_q == D_V);
    busy      = (state_q != S_IDLE);
    err       = err_q;
    dl_clear  = dl_clear_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fcnt_d     = fcnt_q;
    inflight_d = inflight_q;
    err_d      = 1'b0;
    dl_clear_d = 1'b0;
    frame_inc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d      = '0;
        fcnt_d     = '0;
        inflight_d = 1'b0;
        if (in_valid && in_sof) begin
          state_d = S_RUN;
          cnt_d   = N_LOG2'(1);
        end
      end
      S_RUN: begin
        if (wrap_pend) begin
          if (in_valid && in_sof) begin
            cnt_d = N_LOG2'(1);
          end else if (D == 1) begin
            state_d    = S_IDLE;
            inflight_d = 1'b0;
          end else begin
            state_d    = S_FLUSH;
            fcnt_d     = N_LOG2'(1);
            inflight_d = 1'b0;
          end
        end else if (!in_valid || in_sof) begin
          state_d    = S_IDLE;
          cnt_d      = '0;
          inflight_d = 1'b0;
          err_d      = 1'b1;
          dl_clear_d = 1'b1;
        end else begin
          cnt_d = cnt_q + N_LOG2'(1);
          if (cnt_q == LAST) begin
            inflight_d = 1'b1;
            frame_inc  = 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (fcnt_q == D_M1) begin
          state_d = S_IDLE;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + N_LOG2'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        fcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      fcnt_q     <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
      dl_clear_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fcnt_q     <= fcnt_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
      dl_clear_q <= dl_clear_d;
    end
  end

`ifdef SDF_CTRL_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (frame_inc && (frame_cnt_q != 16'hffff)) frame_cnt_d = frame_cnt_q + 16'd1;
    if (err_d && (err_cnt_q != 8'hff))          err_cnt_d   = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  logic unused_frame_inc;
  assign unused_frame_inc = frame_inc;
`endif

endmodule

// File: doc/sdf_stage_ctrl.md
# sdf_stage_ctrl

Sequencer for one radix-2 single-delay-feedback (SDF) FFT pipeline stage. It tracks the sample index within each frame, drives the stage's butterfly/bypass select and twiddle-ROM address, qualifies stage output valid/start-of-frame, and drains the stage's feedback delay line after the last frame. It sits beside the stage datapath: the butterfly, the D-cycle feedback delay line and the twiddle multiplier. It is instantiated once per stage.

## Interface
- N_LOG2, 4, log2 of FFT size N
- STAGE, 0, stage index 0..N_LOG2-1; stage delay D = 2^(N_LOG2-STAGE-1)
- clk  in  1  rising-edge clock; single clock domain
- clear  in  1  synchronous, active-high reset
- in_valid  in  1  input sample present this cycle
- in_sof  in  1  first sample of a frame; meaningful only with in_valid
- bf_sel  out  1  0 = bypass/fill, 1 = butterfly
- tw_en  out  1  twiddle multiply applies to this cycle's stage output
- tw_addr  out  N_LOG2-1  twiddle ROM address
- out_valid  out  1  stage output sample valid
- out_sof  out  1  first output sample of a frame
- dl_clear  out  1  one-cycle clear pulse to the feedback delay line
- err  out  1  one-cycle protocol-error pulse
- busy  out  1  state != IDLE

## Operation
- Counter cnt, N_LOG2 bits: index of the current input sample. Phase p = cnt mod 2D.
- States:
  - IDLE: cnt = 0. in_valid&in_sof -> RUN with cnt=1. in_valid without in_sof is ignored.
  - RUN: each in_valid increments cnt, wrapping at N.
    - At the wrap (cnt = N-1 consumed): in_valid&in_sof in the next cycle continues RUN back-to-back with no flush. Otherwise go to FLUSH.
    - in_valid=0 mid-frame (gap) -> abort.
    - in_sof with cnt != 0 -> abort.
  - FLUSH: D cycles; fcnt counts 0..D-1. Inputs are ignored, including in_sof. Then IDLE.
- Abort: err=1 and dl_clear=1 for the next cycle; state goes to IDLE with cnt=0.
- bf_sel = 1 iff state=RUN and p >= D.
- tw_en = 1 iff (RUN, p < D and a butterfly half has completed since sof) or FLUSH.
- tw_addr = (p mod D) << STAGE in RUN, and fcnt << STAGE in FLUSH. Truncate to N_LOG2-1 bits. Drive 0 when tw_en=0.
- out_valid:
  - RUN: in_valid & (cnt >= D or a previous frame is in flight).
  - FLUSH: 1.
- out_sof = out_valid & (frame output index = 0), i.e. input index D of each frame.
- The output stream carries exactly N samples per frame.
- busy = (state != IDLE).

## Timing
- bf_sel, tw_en, tw_addr, out_valid and out_sof are combinational decodes of registered state/cnt/fcnt plus in_valid. They apply to the sample in the same cycle.
- err and dl_clear are registered, one cycle after the offending cycle.
- Stage latency, input index k to output index k, is D cycles. The feedback delay line is built with a total latency of exactly D cycles.
- clear has priority over all events. In the cycle after clear is sampled: state=IDLE, cnt=fcnt=0, and all outputs are 0, including err and dl_clear. clear mid-frame or mid-flush discards the frame with no err. The delay line is cleared by clear directly.
- Gap and sof-misplacement in the same cycle produce a single err pulse.
- A new sof arriving during FLUSH is not accepted. The source must wait for busy=0.

## Configuration
- SDF_CTRL_STATS_EN defined: adds frame_cnt (out, 16) and err_cnt (out, 8).
  - Both are saturating counters, reset by clear.
  - frame_cnt increments on each completed input frame (wrap or flush entry).
  - err_cnt increments on each err pulse.
- Undefined: these ports and counters are absent. Behaviour is otherwise identical.

## Test plan
All cases use N_LOG2=4, STAGE=1, so D=4. Cycle 0 is the sof cycle.

- Single frame, in_valid cycles 0-15: bf_sel = 0 in cycles 0-3 and 8-11, 1 in cycles 4-7 and 12-15 -> out_valid in cycles 4-19; out_sof in cycle 4; FLUSH in cycles 16-19; tw_en in 8-11 and 16-19 with tw_addr 0,2,4,6 in each window; busy=0 from cycle 20.
- Two back-to-back frames, sof at 0 and 16 -> no flush until 32; out_valid continuous 4-35; out_sof at 4 and 20; tw_en also in cycles 16-19 with tw_addr 0,2,4,6.
- Gap at cycle 6 -> out_valid=0 in cycle 6; err=dl_clear=1 in cycle 7; busy=0 in cycle 7; a following sof restarts cleanly with out_sof 4 cycles later.
- in_sof at cnt=5 -> err pulse next cycle, IDLE. in_valid without sof while IDLE -> ignored, no err.
- clear asserted at cycle 10 -> all outputs 0 at cycle 11, no err; clear during FLUSH cycle 17 -> IDLE at 18.
- With SDF_CTRL_STATS_EN: 3 frames plus 2 gap errors -> frame_cnt=3, err_cnt=2; 300 errors -> err_cnt holds 255.
